// File: rtl/bicubic_upsample_pipe_pkg.sv
// Shared constants for the 4x bicubic upsampler: Keys kernel (a=-0.5)
// rows per phase in 7 fractional bits, coefficient width and lookup.
package bicubic_upsample_pipe_pkg;

  localparam int COEF_WIDTH = 9;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  localparam coef_t COEF_P0_0 = 9'sd0;
  localparam coef_t COEF_P0_1 = 9'sd128;
  localparam coef_t COEF_P0_2 = 9'sd0;
  localparam coef_t COEF_P0_3 = 9'sd0;
  localparam coef_t COEF_P1_0 = -9'sd9;
  localparam coef_t COEF_P1_1 = 9'sd111;
  localparam coef_t COEF_P1_2 = 9'sd29;
  localparam coef_t COEF_P1_3 = -9'sd3;
  localparam coef_t COEF_P2_0 = -9'sd8;
  localparam coef_t COEF_P2_1 = 9'sd72;
  localparam coef_t COEF_P2_2 = 9'sd72;
  localparam coef_t COEF_P2_3 = -9'sd8;
  localparam coef_t COEF_P3_0 = -9'sd3;
  localparam coef_t COEF_P3_1 = 9'sd29;
  localparam coef_t COEF_P3_2 = 9'sd111;
  localparam coef_t COEF_P3_3 = -9'sd9;

  // Tap i of the kernel row for phase p.
  function automatic coef_t coef(
    input logic [1:0] p,
    input logic [1:0] i
  );
    coef_t r;
    r = '0;
    unique case ({p, i})
      4'h0: r = COEF_P0_0;
      4'h1: r = COEF_P0_1;
      4'h2: r = COEF_P0_2;
      4'h3: r = COEF_P0_3;
      4'h4: r = COEF_P1_0;
      4'h5: r = COEF_P1_1;
      4'h6: r = COEF_P1_2;
      4'h7: r = COEF_P1_3;
      4'h8: r = COEF_P2_0;
      4'h9: r = COEF_P2_1;
      4'ha: r = COEF_P2_2;
      4'hb: r = COEF_P2_3;
      4'hc: r = COEF_P3_0;
      4'hd: r = COEF_P3_1;
      4'he: r = COEF_P3_2;
      4'hf: r = COEF_P3_3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bicubic_upsample_pipe_dot4.sv
// bicubic_dot4: signed 4-tap dot product, round-half-up >>> FRAC,
// optional clamp to [0, 2^OW-1]. Ports: x (4 signed taps), c (coefs), y.
module bicubic_dot4
  import bicubic_upsample_pipe_pkg::*;
#(
  parameter int IW    = 9,
  parameter int OW    = 10,
  parameter int FRAC  = 7,
  parameter bit CLAMP = 1'b0
) (
  input  logic [4*IW-1:0]         x,
  input  logic [4*COEF_WIDTH-1:0] c,
  output logic [OW-1:0]           y
);

  localparam int AW = IW + COEF_WIDTH + 2;
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] MAXV = AW'(2 ** OW - 1);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sh;
  logic signed [AW-1:0] xe;
  logic signed [AW-1:0] ce;

  always_comb begin
    acc = HALF;
    xe  = '0;
    ce  = '0;
    for (int i = 0; i < 4; i++) begin
      xe  = AW'($signed(x[i*IW +: IW]));
      ce  = AW'($signed(c[i*COEF_WIDTH +: COEF_WIDTH]));
      acc = acc + xe * ce;
    end
    sh = acc >>> FRAC;
  end

  generate
    if (CLAMP) begin : g_clamp
      always_comb begin
        if (sh < 0)
          y = '0;
        else if (sh > MAXV)
          y = '1;
        else
          y = OW'(sh);
      end
    end else begin : g_wrap
      assign y = OW'(sh);
    end
  endgenerate

endmodule

// File: rtl/bicubic_upsample_pipe.sv
// 4x bicubic upsampler: W (window) -> T (vertical pass) -> O (horizontal
// pass, clamped); bf_req_* in, bcci_rsp_* out. Option: BICUBIC_NEAREST_MODE_EN.
module bicubic_upsample_pipe
  import bicubic_upsample_pipe_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8,
  parameter int NUM_CH        = 3,
  parameter int COEF_FRAC     = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              bf_req_valid,
  output logic                              bcci_req_ready,
  input  logic [NUM_CH*16*CHANNEL_WIDTH-1:0] bf_req_window,
`ifdef BICUBIC_NEAREST_MODE_EN
  input  logic                              bf_req_nearest,
`endif
  output logic                              bcci_rsp_valid,
  input  logic                              bf_rsp_ready,
  output logic [NUM_CH*4*CHANNEL_WIDTH-1:0] bcci_rsp_data,
  output logic [1:0]                        bcci_rsp_row,
  output logic                              bcci_rsp_last
);

  localparam int CW = CHANNEL_WIDTH;
  localparam int TW = CW + 2;
  localparam int WW = NUM_CH * 16 * CW;

  logic [WW-1:0]          win_q;
  logic                   win_vld;
  logic [1:0]             phase;
  logic                   near_d;
  logic                   near_q;
  logic [NUM_CH*4*TW-1:0] t_d;
  logic [NUM_CH*4*TW-1:0] t_q;
  logic                   t_vld;
  logic [1:0]             t_row;
  logic                   t_last;
  logic [NUM_CH*4*CW-1:0] o_d;
  logic [NUM_CH*4*CW-1:0] o_q;
  logic                   o_vld;
  logic [1:0]             o_row;
  logic                   o_last;
  logic                   w_adv;
  logic                   t_adv;
  logic                   o_pop;
  logic                   load;
  logic [4*COEF_WIDTH-1:0] t_coef;

`ifdef BICUBIC_NEAREST_MODE_EN
  assign near_d = bf_req_nearest;
`else
  assign near_d = 1'b0;
`endif

  assign o_pop = o_vld & bf_rsp_ready;
  assign t_adv = t_vld & (~o_vld | bf_rsp_ready);
  assign w_adv = win_vld & (~t_vld | t_adv);
  assign bcci_req_ready =
    rst_n & (~win_vld | ((phase == 2'd3) & w_adv));
  assign load = bf_req_valid & bcci_req_ready;

  always_comb begin
    t_coef = '0;
    for (int i = 0; i < 4; i++)
      t_coef[i*COEF_WIDTH +: COEF_WIDTH] = coef(phase, 2'(i));
  end

  genvar c, k, r;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      for (k = 0; k < 4; k++) begin : g_col
        logic [4*(CW+1)-1:0] tx;
        logic [TW-1:0]       tv;
        logic [4*COEF_WIDTH-1:0] oc;
        for (r = 0; r < 4; r++) begin : g_tap
          assign tx[r*(CW+1) +: CW+1] =
            {1'b0, win_q[(c*16+r*4+k)*CW +: CW]};
          assign oc[r*COEF_WIDTH +: COEF_WIDTH] =
            coef(2'(k), 2'(r));
        end
        bicubic_dot4 #(
          .IW(CW+1), .OW(TW), .FRAC(COEF_FRAC), .CLAMP(1'b0)
        ) u_vert (
          .x(tx), .c(t_coef), .y(tv)
        );
        // Nearest: all columns carry the centre pixel; the horizontal
        // kernel rows sum to unity, so O reproduces it exactly.
        assign t_d[(c*4+k)*TW +: TW] =
          near_q ? TW'(win_q[(c*16+5)*CW +: CW]) : tv;
        // Here k indexes the output pixel j of the horizontal pass.
        bicubic_dot4 #(
          .IW(TW), .OW(CW), .FRAC(COEF_FRAC), .CLAMP(1'b1)
        ) u_horz (
          .x(t_q[c*4*TW +: 4*TW]), .c(oc),
          .y(o_d[(c*4+k)*CW +: CW])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_vld <= 1'b0;
      phase   <= 2'd0;
      t_vld   <= 1'b0;
      o_vld   <= 1'b0;
    end else begin
      if (load) begin
        win_vld <= 1'b1;
        phase   <= 2'd0;
      end else if (w_adv) begin
        phase <= phase + 2'd1;
        if (phase == 2'd3)
          win_vld <= 1'b0;
      end
      if (w_adv)
        t_vld <= 1'b1;
      else if (t_adv)
        t_vld <= 1'b0;
      if (t_adv)
        o_vld <= 1'b1;
      else if (o_pop)
        o_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      win_q  <= bf_req_window;
      near_q <= near_d;
    end
    if (w_adv) begin
      t_q    <= t_d;
      t_row  <= phase;
      t_last <= (phase == 2'd3);
    end
    if (t_adv) begin
      o_q    <= o_d;
      o_row  <= t_row;
      o_last <= t_last;
    end
  end

  assign bcci_rsp_valid = o_vld;
  assign bcci_rsp_data  = o_q;
  assign bcci_rsp_row   = o_row;
  assign bcci_rsp_last  = o_last;

endmodule

// File: tb/tb_bicubic_upsample_pipe.sv
// Scoreboard bench for bicubic_upsample_pipe: driver pushes expected beats
// from an arithmetic kernel model, a negedge monitor pops and compares.
module tb_bicubic_upsample_pipe;

  localparam int CW   = 8;
  localparam int NCH  = 3;
  localparam int WW   = NCH * 16 * CW;
  localparam int DW   = NCH * 4 * CW;
  localparam int FRAC = 7;

  typedef struct {
    logic [DW-1:0] d;
    int            row;
    bit            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bf_req_valid = 1'b0;
  logic [WW-1:0] bf_req_window = '0;
`ifdef BICUBIC_NEAREST_MODE_EN
  logic          bf_req_nearest = 1'b0;
`endif
  logic          bcci_req_ready;
  logic          bcci_rsp_valid;
  logic          bf_rsp_ready;
  logic [DW-1:0] bcci_rsp_data;
  logic [1:0]    bcci_rsp_row;
  logic          bcci_rsp_last;

  logic rdy_val  = 1'b1;
  logic rand_rdy = 1'b0;
  logic rnd_bit  = 1'b1;
  assign bf_rsp_ready = rand_rdy ? rnd_bit : rdy_val;

  bicubic_upsample_pipe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bf_req_valid  (bf_req_valid),
    .bcci_req_ready(bcci_req_ready),
    .bf_req_window (bf_req_window),
`ifdef BICUBIC_NEAREST_MODE_EN
    .bf_req_nearest(bf_req_nearest),
`endif
    .bcci_rsp_valid(bcci_rsp_valid),
    .bf_rsp_ready  (bf_rsp_ready),
    .bcci_rsp_data (bcci_rsp_data),
    .bcci_rsp_row  (bcci_rsp_row),
    .bcci_rsp_last (bcci_rsp_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  int KER[4][4] = '{'{0, 128, 0, 0}, '{-9, 111, 29, -3},
                    '{-8, 72, 72, -8}, '{-3, 29, 111, -9}};

  beat_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_pop = 0;
  int hs_cyc = 0;
  int cur_streak = 0;
  int max_streak = 0;

  task automatic chk_i(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int pix(input logic [WW-1:0] w, input int c,
                             input int r, input int k);
    return int'(w[(c*16+r*4+k)*CW +: CW]);
  endfunction

  function automatic int rnd(input int s);
    return (s + (1 << (FRAC - 1))) >>> FRAC;
  endfunction

  // Reference: separable Keys interpolation in plain integer arithmetic.
  function automatic void push_expect(input logic [WW-1:0] w,
                                      input bit near);
    beat_t b;
    int t[4];
    int s;
    int o;
    for (int p = 0; p < 4; p++) begin
      b.d = '0;
      b.row = p;
      b.last = (p == 3);
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < 4; k++) begin
          if (near) begin
            t[k] = pix(w, c, 1, 1);
          end else begin
            s = 0;
            for (int r = 0; r < 4; r++)
              s += KER[p][r] * pix(w, c, r, k);
            t[k] = rnd(s);
          end
        end
        for (int j = 0; j < 4; j++) begin
          s = 0;
          for (int k = 0; k < 4; k++)
            s += KER[j][k] * t[k];
          o = rnd(s);
          if (o < 0) o = 0;
          if (o > 255) o = 255;
          b.d[(c*4+j)*CW +: CW] = CW'(o);
        end
      end
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [WW-1:0] win_rows(input int a, input int b,
                                             input int c, input int d);
    logic [WW-1:0] w;
    int v[4];
    v = '{a, b, c, d};
    w = '0;
    for (int ch = 0; ch < NCH; ch++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          w[(ch*16+r*4+k)*CW +: CW] = CW'(v[r]);
    return w;
  endfunction

  function automatic logic [WW-1:0] win_cols(input int a, input int b,
                                             input int c, input int d);
    logic [WW-1:0] w;
    int v[4];
    v = '{a, b, c, d};
    w = '0;
    for (int ch = 0; ch < NCH; ch++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          w[(ch*16+r*4+k)*CW +: CW] = CW'(v[k]);
    return w;
  endfunction

  function automatic logic [WW-1:0] win_rand();
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < NCH * 16; i++)
      w[i*CW +: CW] = CW'($urandom);
    return w;
  endfunction

  // Monitor: compare every accepted beat, check hold under backpressure.
  logic          hold_chk = 1'b0;
  logic [DW-1:0] hold_d;
  logic [1:0]    hold_row;
  logic          hold_last;

  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (hold_chk) begin
        chk_i("hold_valid", bcci_rsp_valid, 1);
        chk_v("hold_data", bcci_rsp_data, hold_d);
        chk_i("hold_row", bcci_rsp_row, hold_row);
        chk_i("hold_last", bcci_rsp_last, hold_last);
      end
      hold_chk  = bcci_rsp_valid & ~bf_rsp_ready;
      hold_d    = bcci_rsp_data;
      hold_row  = bcci_rsp_row;
      hold_last = bcci_rsp_last;
      if (bcci_rsp_valid) begin
        cur_streak++;
        if (cur_streak > max_streak) max_streak = cur_streak;
      end else begin
        cur_streak = 0;
      end
      if (bcci_rsp_valid && bf_rsp_ready) begin
        chk_i("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk_v("beat_data", bcci_rsp_data, b.d);
          chk_i("beat_row", bcci_rsp_row, b.row);
          chk_i("beat_last", bcci_rsp_last, b.last);
        end
        n_pop++;
      end
    end else begin
      hold_chk = 1'b0;
      cur_streak = 0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send(input logic [WW-1:0] w, input bit near);
    int n;
    bit eff;
    n = 0;
`ifdef BICUBIC_NEAREST_MODE_EN
    eff = near;
    bf_req_nearest = near;
`else
    eff = 1'b0;
`endif
    bf_req_window = w;
    bf_req_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (bcci_req_ready) break;
      n++;
      if (n > 200) break;
    end
    chk_i("req_handshake_in_time", n <= 200, 1);
    hs_cyc = cyc;
    if (n <= 200) push_expect(w, eff);
    @(posedge clk);
    #1 bf_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bcci_rsp_valid) break;
    end
    chk_i("drain_in_time", n < 400, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int hs[3];
    logic [WW-1:0] w;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("reset_rsp_valid", bcci_rsp_valid, 0);
    chk_i("reset_req_ready", bcci_req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_i("req_ready_after_reset", bcci_req_ready, 1);
    sync();

    rdy_val = 1'b1;
    send(win_rows(100, 100, 100, 100), 1'b0);
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bcci_rsp_valid) break;
    end
    chk_i("first_beat_latency", cyc - hs_cyc, 3);
    drain();

    send(win_cols(0, 0, 255, 255), 1'b0);
    drain();

    send(win_rows(0, 255, 255, 0), 1'b0);
    send(win_rows(255, 0, 0, 255), 1'b0);
    drain();

    send(win_rand(), 1'b0);
    rdy_val = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bcci_rsp_valid) break;
    end
    chk_i("bp_row0_present", bcci_rsp_valid, 1);
    @(posedge clk);
    #1 rdy_val = 1'b1;
    @(posedge clk);
    #1 rdy_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_i("bp_row_held", bcci_rsp_row, 1);
      chk_i("bp_req_ready_low", bcci_req_ready, 0);
    end
    @(posedge clk);
    #1 rdy_val = 1'b1;
    drain();

    max_streak = 0;
    for (int i = 0; i < 3; i++) begin
      send(win_rand(), 1'b0);
      hs[i] = hs_cyc;
    end
    drain();
    chk_i("b2b_gap_1", hs[1] - hs[0], 4);
    chk_i("b2b_gap_2", hs[2] - hs[1], 4);
    chk_i("b2b_streak", max_streak, 12);

    base = n_pop;
    send(win_rand(), 1'b0);
    for (n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (n_pop >= base + 2) break;
    end
    chk_i("reset_test_two_beats", n_pop - base, 2);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_i("mid_reset_req_ready", bcci_req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_i("mid_reset_rsp_valid", bcci_rsp_valid, 0);
    chk_i("mid_reset_req_ready_after", bcci_req_ready, 1);
    sync();
    send(win_rand(), 1'b0);
    drain();

`ifdef BICUBIC_NEAREST_MODE_EN
    w = win_rand();
    for (int c = 0; c < NCH; c++)
      w[(c*16+5)*CW +: CW] = 8'd77;
    send(w, 1'b1);
    drain();
`endif

    rand_rdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      w = win_rand();
      send(w, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) sync();
    end
    drain();
    rand_rdy = 1'b0;
    drain();
    chk_i("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
